// File: rtl/nbody_pkg.sv
// Shared types for the n-body engine: body and force record layouts, the
// integrator state encoding and the 16-bit saturating clamp.
package nbody_pkg;

    typedef struct packed {
        logic signed [15:0] x;
        logic signed [15:0] y;
        logic signed [15:0] vx;
        logic signed [15:0] vy;
        logic        [15:0] mass;
    } body_t;

    typedef struct packed {
        logic        [15:0] pad;
        logic signed [31:0] fx;
        logic signed [31:0] fy;
    } force_rec_t;

    localparam int FORCE_BASE_DEFAULT = 400;

    typedef enum logic [3:0] {
        S_IDLE,
        S_RD_BODY,
        S_LATCH_BODY,
        S_RD_FORCE,
        S_LATCH_FORCE,
        S_CALC_V,
        S_CALC_X,
        S_WRITE,
        S_NEXT,
        S_DONE
    } state_t;

    function automatic logic signed [15:0] sat16(input logic signed [48:0] v);
        if (v > 49'sd32767)
            return 16'sh7fff;
        else if (v < -49'sd32768)
            return 16'sh8000;
        else
            return v[15:0];
    endfunction

endpackage

// File: rtl/body_integrator_sat_mac.sv
// Saturating multiply-accumulate: out = sat16(acc + ((a*b) >>> FRAC)).
// The shift floors toward -inf; no rounding offset is added.
module sat_mac
    import nbody_pkg::*;
#(
    parameter int FRAC = 12
) (
    input  logic signed [31:0] a,
    input  logic signed [15:0] b,
    input  logic signed [15:0] acc,
    output logic signed [15:0] out
);

    logic signed [47:0] prod;
    logic signed [47:0] scaled;
    logic signed [48:0] sum;

    always_comb begin
        prod   = 48'(a) * 48'(b);
        scaled = prod >>> FRAC;
        sum    = 49'(scaled) + 49'(acc);
        out    = sat16(sum);
    end

endmodule

// File: rtl/body_integrator.sv
// Semi-implicit Euler timestep pass: for each body read body and force record,
// update velocity then position with the new velocity, and write the body back.
module body_integrator
    import nbody_pkg::*;
#(
    parameter int N          = 16,
    parameter int ADDR_WIDTH = 15,
    parameter int FORCE_BASE = FORCE_BASE_DEFAULT,
    parameter int DT_NUM     = 41,
    parameter int FRAC       = 12
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_wr_en,
    output logic [79:0]           mem_wr_data,
    input  logic [79:0]           mem_rd_data
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic signed [15:0] DT = 16'(DT_NUM);

    state_t             state;
    logic [IW-1:0]      idx;
    body_t              body;
    logic signed [31:0] fx;
    logic signed [31:0] fy;
    force_rec_t         frc;

    logic               calc_x;
    logic signed [31:0] mac_ax, mac_ay;
    logic signed [15:0] acc_x, acc_y, res_x, res_y;

    assign frc = force_rec_t'(mem_rd_data);

    // One MAC per axis, shared: CALC_V integrates force into v, CALC_X integrates v into x.
    always_comb begin
        calc_x = (state == S_CALC_X);
        mac_ax = calc_x ? 32'(body.vx) : fx;
        mac_ay = calc_x ? 32'(body.vy) : fy;
        acc_x  = calc_x ? body.x : body.vx;
        acc_y  = calc_x ? body.y : body.vy;
    end

    sat_mac #(.FRAC(FRAC)) u_mac_x (.a(mac_ax), .b(DT), .acc(acc_x), .out(res_x));
    sat_mac #(.FRAC(FRAC)) u_mac_y (.a(mac_ay), .b(DT), .acc(acc_y), .out(res_y));

    // NOTE: all state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            idx   <= '0;
            body  <= '0;
            fx    <= '0;
            fy    <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: if (start) state <= S_RD_BODY;
                S_RD_BODY:      state <= S_LATCH_BODY;
                S_LATCH_BODY: begin
                    body  <= body_t'(mem_rd_data);
                    state <= S_RD_FORCE;
                end
                S_RD_FORCE:     state <= S_LATCH_FORCE;
                S_LATCH_FORCE: begin
                    fx    <= frc.fx;
                    fy    <= frc.fy;
                    state <= S_CALC_V;
                end
                S_CALC_V: begin
                    body.vx <= res_x;
                    body.vy <= res_y;
                    state   <= S_CALC_X;
                end
                S_CALC_X: begin
                    body.x <= res_x;
                    body.y <= res_y;
                    state  <= S_WRITE;
                end
                S_WRITE:        state <= S_NEXT;
                S_NEXT: begin
                    if (idx == IW'(N - 1)) begin
                        idx   <= '0;
                        state <= S_DONE;
                    end else begin
                        idx   <= idx + 1'b1;
                        state <= S_RD_BODY;
                    end
                end
                default:        state <= S_IDLE;
            endcase
        end
    end

    // NOTE: every output gets a default first so this decode cannot infer latches.
    always_comb begin
        mem_addr    = '0;
        mem_wr_en   = 1'b0;
        mem_wr_data = '0;
        done        = 1'b0;
        case (state)
            S_RD_BODY:  mem_addr = ADDR_WIDTH'(idx);
            S_RD_FORCE: mem_addr = ADDR_WIDTH'(FORCE_BASE) + ADDR_WIDTH'(idx);
            S_WRITE: begin
                mem_addr    = ADDR_WIDTH'(idx);
                // A reset arriving during WRITE must not let the half-finished body reach RAM.
                mem_wr_en   = !reset;
                mem_wr_data = body;
            end
            S_DONE:     done = 1'b1;
            default:    ;
        endcase
    end

endmodule

// File: tb/tb_body_integrator.sv
// Directed bench: two N=4 integrators (DT=1.0 and DT=41/4096) on private RAM
// models, with a write scoreboard plus per-cycle protocol checks.
module tb_body_integrator;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        done_a, done_b;
    logic [14:0] addr_a, addr_b;
    logic        wr_a, wr_b;
    logic [79:0] wd_a, wd_b, rd_a, rd_b;

    logic [79:0] mem_a [0:511];
    logic [79:0] mem_b [0:511];
    logic        ld_en = 1'b0;
    logic [8:0]  ld_addr = '0;
    logic [79:0] ld_da = '0, ld_db = '0;

    typedef struct {
        logic [14:0] addr;
        logic [79:0] data;
        int          cyc;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];

    int cyc = 0;
    int t0 = 0;
    int n_cmp = 0;
    int n_err = 0;

    logic [79:0] init_a [4], frc_a [4], exp1_a [4], exp2_a [4];
    logic [79:0] init_b [4], frc_b [4], exp1_b [4], exp2_b [4];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    body_integrator #(.N(4), .DT_NUM(4096)) u_fast (
        .clk(clk), .reset(reset), .start(start), .done(done_a),
        .mem_addr(addr_a), .mem_wr_en(wr_a), .mem_wr_data(wd_a), .mem_rd_data(rd_a)
    );

    body_integrator #(.N(4)) u_def (
        .clk(clk), .reset(reset), .start(start), .done(done_b),
        .mem_addr(addr_b), .mem_wr_en(wr_b), .mem_wr_data(wd_b), .mem_rd_data(rd_b)
    );

    always @(posedge clk) begin
        if (ld_en) begin
            mem_a[ld_addr] <= ld_da;
            mem_b[ld_addr] <= ld_db;
        end else begin
            if (wr_a) mem_a[addr_a[8:0]] <= wd_a;
            if (wr_b) mem_b[addr_b[8:0]] <= wd_b;
        end
        rd_a <= mem_a[addr_a[8:0]];
        rd_b <= mem_b[addr_b[8:0]];
    end

    task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [79:0] mk_body(input int x, y, vx, vy, m);
        return {16'(x), 16'(y), 16'(vx), 16'(vy), 16'(m)};
    endfunction

    function automatic logic [79:0] mk_force(input logic [15:0] pad, input logic [31:0] fx, fy);
        return {pad, fx, fy};
    endfunction

    function automatic logic [14:0] exp_addr(input int k);
        int ph, bi;
        if (k < 1 || k > 32) return '0;
        ph = (k - 1) % 8;
        bi = (k - 1) / 8;
        if (ph == 0 || ph == 6) return 15'(bi);
        if (ph == 2) return 15'(400 + bi);
        return '0;
    endfunction

    // Scoreboard: every DUT write must match the next expected address/data/cycle.
    always @(negedge clk) begin
        exp_t e;
        if (wr_a) begin
            n_cmp++;
            assert (q_a.size() > 0) else begin
                n_err++;
                $error("FAIL fast_unexpected_write: observed addr %0d at cycle %0d expected no write", addr_a, cyc - t0);
            end
            if (q_a.size() > 0) begin
                e = q_a.pop_front();
                check("fast_wr_addr", 80'(addr_a), 80'(e.addr));
                check("fast_wr_data", wd_a, e.data);
                check("fast_wr_cycle", 80'(cyc - t0), 80'(e.cyc));
            end
        end
        if (wr_b) begin
            n_cmp++;
            assert (q_b.size() > 0) else begin
                n_err++;
                $error("FAIL def_unexpected_write: observed addr %0d at cycle %0d expected no write", addr_b, cyc - t0);
            end
            if (q_b.size() > 0) begin
                e = q_b.pop_front();
                check("def_wr_addr", 80'(addr_b), 80'(e.addr));
                check("def_wr_data", wd_b, e.data);
                check("def_wr_cycle", 80'(cyc - t0), 80'(e.cyc));
            end
        end
    end

    task automatic load_word(input int addr, input logic [79:0] da, db);
        ld_addr = 9'(addr);
        ld_da   = da;
        ld_db   = db;
        ld_en   = 1'b1;
        @(negedge clk);
        ld_en   = 1'b0;
    endtask

    task automatic push(input int i, input logic [79:0] da, db);
        q_a.push_back('{addr: 15'(i), data: da, cyc: 7 + 8 * i});
        q_b.push_back('{addr: 15'(i), data: db, cyc: 7 + 8 * i});
    endtask

    task automatic begin_pass;
        @(negedge clk);
        t0    = cyc;
        start = 1'b1;
    endtask

    task automatic wait_done(input string tag);
        int k;
        for (k = 0; k < 200 && !(done_a && done_b); k++) @(negedge clk);
        check({tag, "_done_a"}, 80'(done_a), 80'(1));
        check({tag, "_done_b"}, 80'(done_b), 80'(1));
        check({tag, "_drain_a"}, 80'(q_a.size()), 80'(0));
        check({tag, "_drain_b"}, 80'(q_b.size()), 80'(0));
    endtask

    initial begin
        // DT = 1.0: plain update, force, saturation both signs, extreme forces with pad set.
        init_a[0] = mk_body(100, -50, 10, 0, 5);
        frc_a[0]  = mk_force(16'h0, 32'd0, 32'd0);
        exp1_a[0] = mk_body(110, -50, 10, 0, 5);
        exp2_a[0] = mk_body(120, -50, 10, 0, 5);
        init_a[1] = mk_body(100, -50, 0, 0, 7);
        frc_a[1]  = mk_force(16'h0, 32'd3, -32'sd2);
        exp1_a[1] = mk_body(103, -52, 3, -2, 7);
        exp2_a[1] = mk_body(109, -56, 6, -4, 7);
        init_a[2] = mk_body(32760, -32760, 32760, -32760, 9);
        frc_a[2]  = mk_force(16'h0, 32'd100, -32'sd100);
        exp1_a[2] = mk_body(32767, -32768, 32767, -32768, 9);
        exp2_a[2] = exp1_a[2];
        init_a[3] = mk_body(0, 0, 0, 0, 1);
        frc_a[3]  = mk_force(16'hdead, 32'h7fffffff, 32'h80000000);
        exp1_a[3] = mk_body(32767, -32768, 32767, -32768, 1);
        exp2_a[3] = exp1_a[3];
        // DT = 41/4096: floor rounding, position below one LSB, large forces, clamp.
        init_b[0] = mk_body(1000, 2000, 5, 5, 3);
        frc_b[0]  = mk_force(16'h0, -32'sd1, 32'd1);
        exp1_b[0] = mk_body(1000, 2000, 4, 5, 3);
        exp2_b[0] = mk_body(1000, 2000, 3, 5, 3);
        init_b[1] = mk_body(0, 0, 0, 0, 2);
        frc_b[1]  = mk_force(16'h0, 32'd100000, -32'sd100000);
        exp1_b[1] = mk_body(10, -11, 1000, -1001, 2);
        exp2_b[1] = mk_body(30, -32, 2000, -2002, 2);
        init_b[2] = mk_body(-5, 7, -100, 100, 16'hffff);
        frc_b[2]  = mk_force(16'h0, 32'd0, 32'd0);
        exp1_b[2] = mk_body(-7, 8, -100, 100, 16'hffff);
        exp2_b[2] = mk_body(-9, 9, -100, 100, 16'hffff);
        init_b[3] = mk_body(32767, -32768, 32767, -32768, 4);
        frc_b[3]  = mk_force(16'h1234, 32'd5000, -32'sd5000);
        exp1_b[3] = init_b[3];
        exp2_b[3] = init_b[3];

        reset = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_done", 80'({done_a, done_b}), 80'(0));
        check("rst_wr_en", 80'({wr_a, wr_b}), 80'(0));
        check("rst_addr", 80'({addr_a, addr_b}), 80'(0));
        check("rst_wr_data", wd_a | wd_b, 80'(0));

        for (int i = 0; i < 4; i++) begin
            load_word(i, init_a[i], init_b[i]);
            load_word(400 + i, frc_a[i], frc_b[i]);
        end

        // Pass 1 with a cycle-by-cycle protocol check; a start at cycle 12 must be ignored.
        begin_pass();
        for (int i = 0; i < 4; i++) push(i, exp1_a[i], exp1_b[i]);
        for (int k = 1; k <= 34; k++) begin
            @(negedge clk);
            start = (k == 12);
            check($sformatf("p1_addr_c%0d", k), 80'(addr_a), 80'(exp_addr(k)));
            check($sformatf("p1_wr_c%0d", k), 80'(wr_a),
                  80'((k <= 32) && ((k - 1) % 8 == 6)));
            check($sformatf("p1_done_c%0d", k), 80'(done_a), 80'(k >= 33));
        end
        check("p1_drain_a", 80'(q_a.size()), 80'(0));
        check("p1_drain_b", 80'(q_b.size()), 80'(0));
        for (int i = 0; i < 4; i++) begin
            check($sformatf("force_kept_a%0d", i), mem_a[400 + i], frc_a[i]);
            check($sformatf("force_kept_b%0d", i), mem_b[400 + i], frc_b[i]);
        end

        // Start in DONE reruns the pass on the already-updated bodies.
        begin_pass();
        for (int i = 0; i < 4; i++) push(i, exp2_a[i], exp2_b[i]);
        @(negedge clk);
        start = 1'b0;
        wait_done("p2");

        // Reset at cycle 10: only body 0 gets written, body 1 stays untouched.
        for (int i = 0; i < 4; i++) load_word(i, init_a[i], init_b[i]);
        begin_pass();
        push(0, exp1_a[0], exp1_b[0]);
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            start = 1'b0;
            reset = (k == 10);
            if (k > 10) check($sformatf("rst_done_c%0d", k), 80'(done_a | done_b), 80'(0));
        end
        check("rst_drain_a", 80'(q_a.size()), 80'(0));
        check("rst_drain_b", 80'(q_b.size()), 80'(0));
        check("rst_body0_a", mem_a[0], exp1_a[0]);
        check("rst_body1_a", mem_a[1], init_a[1]);
        check("rst_body1_b", mem_b[1], init_b[1]);

        // Fresh start after reset begins again at body 0.
        begin_pass();
        push(0, exp2_a[0], exp2_b[0]);
        for (int i = 1; i < 4; i++) push(i, exp1_a[i], exp1_b[i]);
        @(negedge clk);
        start = 1'b0;
        wait_done("p4");
        for (int i = 0; i < 4; i++) begin
            check($sformatf("p4_mem_a%0d", i), mem_a[i], (i == 0) ? exp2_a[0] : exp1_a[i]);
            check($sformatf("p4_mem_b%0d", i), mem_b[i], (i == 0) ? exp2_b[0] : exp1_b[i]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
